mips_alu_issue: RTL and testbench

Operand-issue stage directly upstream of the MIPS ALU: a single-entry ID/EX pipeline register with a valid/ready handshake that converts a decoded instruction into the ALU's `ALUctl`, `A` and `B` inputs. It decodes ALUOp/funct into the 4-bit ALU control code and forwards results from EX/MEM and MEM/WB onto the operand buses. The downstream EX/MEM capture logic consumes `ALUOut`/`Zero` alongside this block's `out_*` sideband.

---
 rtl/mips_alu_issue.sv | 165 ++++++++++++++++
 tb/tb_mips_alu_issue.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_issue.sv
// ID/EX operand-issue register for the MIPS ALU: decodes ALUOp/funct into ALUctl,
// holds one instruction behind a valid/ready handshake and forwards EX/MEM, MEM/WB results.
module mips_alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic              in_alusrc,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALUctl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
);

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic              r_valid;
  logic [3:0]        r_aluctl;
  logic              r_illegal;
  logic              r_regwrite;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic              r_alusrc;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;

  logic              w_accept;
  logic [3:0]        w_ctl;
  logic              w_illegal;
  logic              w_exmem_a;
  logic              w_exmem_b;
  logic              w_memwb_a;
  logic              w_memwb_b;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // ALUOp/funct decode; unknown encodings fall back to add and are flagged illegal
  always_comb begin
    w_ctl     = CTL_ADD;
    w_illegal = 1'b0;
    case (in_aluop)
      2'b00: w_ctl = CTL_ADD;
      2'b01: w_ctl = CTL_SUB;
      2'b10: begin
        case (in_funct)
          FN_ADD:  w_ctl = CTL_ADD;
          FN_SUB:  w_ctl = CTL_SUB;
          FN_AND:  w_ctl = CTL_AND;
          FN_OR:   w_ctl = CTL_OR;
          FN_NOR:  w_ctl = CTL_NOR;
          FN_SLT:  w_ctl = CTL_SLT;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Single-entry pipeline register: flush beats accept, accept beats release
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_aluctl   <= 4'd0;
      r_illegal  <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_alusrc   <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_aluctl   <= w_ctl;
      r_illegal  <= w_illegal;
      r_regwrite <= in_regwrite && !w_illegal;
      r_rd       <= in_rd;
      r_rs       <= in_rs;
      r_rt       <= in_rt;
      r_alusrc   <= in_alusrc;
      r_rs_data  <= in_rs_data;
      r_rt_data  <= in_rt_data;
      r_imm      <= in_imm;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Forwarding hits; register 0 is hardwired and never forwarded
  assign w_exmem_a = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs);
  assign w_exmem_b = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt);
  assign w_memwb_a = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs);
  assign w_memwb_b = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt);

  // The youngest producer (EX/MEM) takes priority over MEM/WB
  always_comb begin
    w_fwd_a = r_rs_data;
    if (w_exmem_a) begin
      w_fwd_a = exmem_result;
    end else if (w_memwb_a) begin
      w_fwd_a = memwb_result;
    end
  end

  always_comb begin
    w_fwd_b = r_rt_data;
    if (w_exmem_b) begin
      w_fwd_b = exmem_result;
    end else if (w_memwb_b) begin
      w_fwd_b = memwb_result;
    end
  end

  assign A            = w_fwd_a;
  assign B            = r_alusrc ? r_imm : w_fwd_b;
  assign out_valid    = r_valid;
  assign ALUctl       = r_aluctl;
  assign out_rd       = r_rd;
  assign out_regwrite = r_regwrite;
  assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Self-checking bench for mips_alu_issue: scoreboard of accepted instructions plus
// per-scenario directed checks.
module tb_mips_alu_issue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OUTW   = 4 + 1 + 1 + REG_AW + 2 * DATA_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic              in_alusrc;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  logic [DATA_W-1:0] in_rs_data, in_rt_data, in_imm;
  logic              in_regwrite;
  logic              flush;
  logic              exmem_regwrite, memwb_regwrite;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        ALUctl;
  logic [DATA_W-1:0] A, B;
  logic [REG_AW-1:0] out_rd;
  logic              out_regwrite;
  logic              out_illegal;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  typedef struct {
    logic [3:0]        ctl;
    logic              ill;
    logic              rw;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              alusrc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } sb_t;

  sb_t sbq[$];

  mips_alu_issue #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .ALUctl(ALUctl), .A(A), .B(B),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table: {illegal, ALUctl}
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [4:0] r;
    r = {1'b1, 4'd2};
    if (op == 2'b00) r = {1'b0, 4'd2};
    else if (op == 2'b01) r = {1'b0, 4'd6};
    else if (op == 2'b10) begin
      if (fn == 6'h20) r = {1'b0, 4'd2};
      else if (fn == 6'h22) r = {1'b0, 4'd6};
      else if (fn == 6'h24) r = {1'b0, 4'd0};
      else if (fn == 6'h25) r = {1'b0, 4'd1};
      else if (fn == 6'h27) r = {1'b0, 4'd12};
      else if (fn == 6'h2A) r = {1'b0, 4'd7};
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ref_fwd(input logic [REG_AW-1:0] idx,
                                                input logic [DATA_W-1:0] dflt);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
    return dflt;
  endfunction

  // Scoreboard: compare presented output on negedge, then predict the coming edge
  always @(negedge clk) begin
    sb_t e;
    sb_t n;
    logic [4:0] d;
    logic [OUTW-1:0] got, exp;
    got = {ALUctl, out_illegal, out_regwrite, out_rd, A, B};
    total++;
    if (sbq.size() == 0) begin
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL sb_unexpected: out_valid=%b with nothing expected, out=%h", out_valid, got);
      end
    end else begin
      e = sbq[0];
      exp = {e.ctl, e.ill, e.rw, e.rd, ref_fwd(e.rs, e.rs_data),
             e.alusrc ? e.imm : ref_fwd(e.rt, e.rt_data)};
      if (out_valid !== 1'b1 || got !== exp) begin
        bad++;
        $display("FAIL sb_output: out_valid=%b out=%h expected valid=1 out=%h", out_valid, got, exp);
      end
    end
    if (reset || flush) begin
      sbq.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready && sbq.size() > 0) begin
        void'(sbq.pop_front());
        n_pop++;
      end
      if (in_valid && in_ready === 1'b1) begin
        d = ref_decode(in_aluop, in_funct);
        n.ctl = d[3:0]; n.ill = d[4]; n.rw = in_regwrite && !d[4]; n.rd = in_rd;
        n.rs = in_rs; n.rt = in_rt; n.alusrc = in_alusrc; n.rs_data = in_rs_data;
        n.rt_data = in_rt_data; n.imm = in_imm;
        sbq.push_back(n);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                       input logic [DATA_W-1:0] imm, input logic [REG_AW-1:0] rd,
                       input logic rw);
    in_valid = 1'b1; in_aluop = op; in_funct = fn; in_alusrc = src;
    in_rs = rs; in_rt = rt; in_rs_data = rsd; in_rt_data = rtd;
    in_imm = imm; in_rd = rd; in_regwrite = rw;
  endtask

  task automatic fwd_off;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(2'b10, 6'h20, 1'b0, 5'd0, 5'd0, 32'h1234, 32'h5678, 32'h9, 5'd1, 1'b1);
    exmem_regwrite = 1'b1; exmem_rd = '0; exmem_result = 32'hDEAD_BEEF;
    memwb_regwrite = 1'b1; memwb_rd = '0; memwb_result = 32'hCAFE_F00D;
    for (int c = 0; c < 2; c++) begin
      tick;
      total++;
      if (out_valid !== 1'b0 || ALUctl !== 4'd0 || A !== 32'd0 || B !== 32'd0) begin
        bad++;
        $display("FAIL reset_state: valid=%b ctl=%0d A=%h B=%h want 0/0/0/0", out_valid, ALUctl, A, B);
      end
      total++;
      if (in_ready !== 1'b1 || out_rd !== '0 || out_regwrite !== 1'b0 || out_illegal !== 1'b0) begin
        bad++;
        $display("FAIL reset_side: in_ready=%b rd=%0d rw=%b ill=%b want 1/0/0/0", in_ready, out_rd, out_regwrite, out_illegal);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_accept: out_valid=%b want 0", out_valid);
    end
    fwd_off();
  endtask

  task automatic test_alu;
    out_ready = 1'b1;
    drive(2'b10, 6'h24, 1'b0, 5'd1, 5'd2, 32'hC, 32'h4, 32'h0, 5'd8, 1'b1);
    tick;
    drive(2'b10, 6'h2A, 1'b0, 5'd1, 5'd2, 32'hF, 32'h6, 32'h0, 5'd9, 1'b1);
    total++;
    if (out_valid !== 1'b1 || ALUctl !== 4'd0 || A !== 32'hC || B !== 32'h4) begin
      bad++;
      $display("FAIL alu_and: valid=%b ctl=%0d A=%h B=%h want 1/0/c/4", out_valid, ALUctl, A, B);
    end
    tick;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ALUctl !== 4'd7 || A !== 32'hF || B !== 32'h6 || out_rd !== 5'd9) begin
      bad++;
      $display("FAIL alu_slt: valid=%b ctl=%0d A=%h B=%h rd=%0d want 1/7/f/6/9", out_valid, ALUctl, A, B, out_rd);
    end
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL alu_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_forward;
    out_ready = 1'b0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    drive(2'b10, 6'h20, 1'b0, 5'd3, 5'd3, 32'h100, 32'h200, 32'h0, 5'd4, 1'b1);
    tick;
    in_valid = 1'b0;
    total++;
    if (A !== 32'h11 || B !== 32'h11) begin
      bad++;
      $display("FAIL fwd_exmem: A=%h B=%h want 11/11", A, B);
    end
    exmem_regwrite = 1'b0;
    #1;
    total++;
    if (A !== 32'h22 || B !== 32'h22) begin
      bad++;
      $display("FAIL fwd_memwb: A=%h B=%h want 22/22", A, B);
    end
    exmem_regwrite = 1'b1; exmem_rd = '0; memwb_rd = '0;
    #1;
    total++;
    if (A !== 32'h100 || B !== 32'h200) begin
      bad++;
      $display("FAIL fwd_reg0: A=%h B=%h want 100/200", A, B);
    end
    out_ready = 1'b1;
    tick;
    fwd_off();
  endtask

  task automatic test_imm_illegal;
    out_ready = 1'b1;
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h55;
    drive(2'b00, 6'h3F, 1'b1, 5'd5, 5'd4, 32'h77, 32'h88, 32'hFFFF_FFFC, 5'd4, 1'b1);
    tick;
    drive(2'b10, 6'h03, 1'b0, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 5'd7, 1'b1);
    total++;
    if (ALUctl !== 4'd2 || A !== 32'h77 || B !== 32'hFFFF_FFFC || out_illegal !== 1'b0) begin
      bad++;
      $display("FAIL imm_add: ctl=%0d A=%h B=%h ill=%b want 2/77/fffffffc/0", ALUctl, A, B, out_illegal);
    end
    tick;
    drive(2'b11, 6'h20, 1'b0, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 5'd7, 1'b1);
    total++;
    if (out_illegal !== 1'b1 || out_regwrite !== 1'b0 || ALUctl !== 4'd2) begin
      bad++;
      $display("FAIL illegal_funct: ill=%b rw=%b ctl=%0d want 1/0/2", out_illegal, out_regwrite, ALUctl);
    end
    tick;
    in_valid = 1'b0;
    total++;
    if (out_illegal !== 1'b1 || out_regwrite !== 1'b0 || ALUctl !== 4'd2) begin
      bad++;
      $display("FAIL illegal_aluop: ill=%b rw=%b ctl=%0d want 1/0/2", out_illegal, out_regwrite, ALUctl);
    end
    tick;
    fwd_off();
  endtask

  task automatic test_stall;
    logic [5:0] fns [6];
    logic [4+DATA_W*2+REG_AW-1:0] snap;
    logic acc;
    int sent;
    int cyc;
    int n0;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h27; fns[5] = 6'h2A;
    sent = 0; cyc = 0; n0 = n_pop; snap = '0;
    while (sent < 10 && cyc < 200) begin
      drive(2'b10, fns[sent % 6], 1'b0, REG_AW'(sent + 1), REG_AW'(sent + 2),
            DATA_W'(32'h1000 + sent), DATA_W'(32'h2000 + sent), 32'h0, REG_AW'(sent + 1), 1'b1);
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (!out_ready && out_valid === 1'b1) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready: in_ready=%b want 0 at cycle %0d", in_ready, cyc);
        end
        if (cyc == 3) snap = {ALUctl, A, B, out_rd};
        else begin
          total++;
          if ({ALUctl, A, B, out_rd} !== snap) begin
            bad++;
            $display("FAIL stall_frozen: out=%h want %h", {ALUctl, A, B, out_rd}, snap);
          end
        end
      end
      acc = in_ready;
      tick;
      cyc++;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL stall_timeout: sent=%0d want 10 within 200 cycles", sent);
    end
    tick; tick; tick;
    total++;
    if (n_pop - n0 !== 10) begin
      bad++;
      $display("FAIL stall_count: delivered=%0d want 10", n_pop - n0);
    end
  endtask

  task automatic test_flush;
    int n0;
    n0 = n_pop;
    out_ready = 1'b0;
    drive(2'b10, 6'h20, 1'b0, 5'd1, 5'd2, 32'hAAA, 32'hBBB, 32'h0, 5'd1, 1'b1);
    tick;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: out_valid=%b want 1", out_valid);
    end
    drive(2'b01, 6'h00, 1'b0, 5'd1, 5'd2, 32'hCCC, 32'hDDD, 32'h0, 5'd2, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_held: out_valid=%b want 0", out_valid);
    end
    drive(2'b01, 6'h00, 1'b0, 5'd3, 5'd4, 32'hEEE, 32'hFFF, 32'h0, 5'd3, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tick;
    total++;
    if (out_valid !== 1'b0 || n_pop !== n0) begin
      bad++;
      $display("FAIL flush_accept: out_valid=%b delivered=%0d want 0/0", out_valid, n_pop - n0);
    end
    out_ready = 1'b0;
    drive(2'b00, 6'h00, 1'b0, 5'd5, 5'd6, 32'h123, 32'h456, 32'h0, 5'd5, 1'b1);
    tick;
    in_valid = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0; out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || ALUctl !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_stall: out_valid=%b ctl=%0d want 0/0", out_valid, ALUctl);
    end
    tick;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_aluop = '0; in_funct = '0; in_alusrc = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_regwrite = 1'b0;
    fwd_off();
    test_reset();
    test_alu();
    test_forward();
    test_imm_illegal();
    test_stall();
    test_flush();
    tick; tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
